// File: rtl/ysyx_lsu_if.sv
// Execute->LSU->writeback handshake plus the LSU memory request/response bus.
// The slave modport is the LSU view; master is the surrounding pipeline/memory.
interface ysyx_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu;
    logic [31:0] in_wdata;
    logic [2:0]  in_funct3;
    logic        in_is_load;
    logic        in_is_store;
    logic [4:0]  in_rd;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_wen;
    logic        out_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport slave (
        input  in_valid, in_alu, in_wdata, in_funct3, in_is_load, in_is_store, in_rd,
        output in_ready,
        output out_valid, out_rd, out_data, out_wen, out_err,
        input  out_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output in_valid, in_alu, in_wdata, in_funct3, in_is_load, in_is_store, in_rd,
        input  in_ready,
        input  out_valid, out_rd, out_data, out_wen, out_err,
        output out_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_lsu.sv
// Load/store stage: one bus access per instruction, load align/extend, ALU pass-through.
// Latency 1 cycle pass-through, 3+ cycles memory op; single instruction in flight, in_ready only in IDLE.
module ysyx_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    ysyx_lsu_if.slave  bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic [31:0]     alu_q, alu_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            st_q, st_d;
    logic            ld_q, ld_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     data_q, data_d;
    logic            wen_q, wen_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            legal_ld, legal_st, misal, is_mem, bad;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alu_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            st_q    <= 1'b0;
            ld_q    <= 1'b0;
            f3_q    <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            st_q    <= st_d;
            ld_q    <= ld_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decode of the incoming instruction, only consumed on the IDLE accept.
    always_comb begin
        legal_ld = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b001) ||
                   (bus.in_funct3 == 3'b010) || (bus.in_funct3 == 3'b100) ||
                   (bus.in_funct3 == 3'b101);
        legal_st = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b001) ||
                   (bus.in_funct3 == 3'b010);
        misal    = ((bus.in_funct3[1:0] == 2'b01) && bus.in_alu[0]) ||
                   ((bus.in_funct3[1:0] == 2'b10) && (bus.in_alu[1:0] != 2'b00));
        is_mem   = bus.in_is_load || bus.in_is_store;
        bad      = (bus.in_is_load && !legal_ld) || (bus.in_is_store && !legal_st) ||
                   (is_mem && misal);
    end

    always_comb begin
        ld_byte = bus.mem_rdata[8*alu_q[1:0] +: 8];
        ld_half = alu_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        unique case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        st_d    = st_q;
        ld_d    = ld_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        data_d  = data_q;
        wen_d   = wen_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        bus.in_ready      = 1'b0;
        bus.out_valid     = 1'b0;
        bus.out_rd        = '0;
        bus.out_data      = '0;
        bus.out_wen       = 1'b0;
        bus.out_err       = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wen       = 1'b0;
        bus.mem_wdata     = '0;
        bus.mem_wstrb     = '0;

        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    alu_d   = bus.in_alu;
                    st_d    = bus.in_is_store;
                    ld_d    = bus.in_is_load;
                    f3_d    = bus.in_funct3;
                    rd_d    = bus.in_rd;
                    data_d  = bus.in_alu;
                    err_d   = bad;
                    wen_d   = !is_mem && (bus.in_rd != 5'd0);
                    wdata_d = '0;
                    wstrb_d = '0;
                    if (bus.in_is_store) begin
                        unique case (bus.in_funct3[1:0])
                            2'b00: begin
                                wdata_d = {4{bus.in_wdata[7:0]}};
                                wstrb_d = 4'b0001 << bus.in_alu[1:0];
                            end
                            2'b01: begin
                                wdata_d = {2{bus.in_wdata[15:0]}};
                                wstrb_d = bus.in_alu[1] ? 4'b1100 : 4'b0011;
                            end
                            default: begin
                                wdata_d = bus.in_wdata;
                                wstrb_d = 4'b1111;
                            end
                        endcase
                    end
                    state_d = (is_mem && !bad) ? REQ : DONE;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_addr      = {alu_q[31:2], 2'b00};
                bus.mem_wen       = st_q;
                bus.mem_wdata     = wdata_q;
                bus.mem_wstrb     = wstrb_q;
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    data_d  = ld_q ? ld_val : alu_q;
                    wen_d   = ld_q && (rd_q != 5'd0);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_d == CW'(TIMEOUT))) begin
                        err_d   = 1'b1;
                        wen_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_rd    = rd_q;
                bus.out_data  = data_q;
                bus.out_wen   = wen_q;
                bus.out_err   = err_q;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
